int_ctrl: RTL and testbench

- Parametrised interrupt/exception controller for the MIPS pipeline CPU.
- Captures up to NUM_SRC request lines into sticky pending bits and applies a per-source mask and the global enable.
- Selects the highest-priority eligible source and raises a held request/acknowledge handshake toward the pipeline front-end.
- On acknowledge, saves the interrupted PC (EPC), then blocks further requests until `iret`. Source 0 is arithmetic overflow and is non-maskable.

---
 rtl/int_pkg.sv | 14 +
 rtl/int_ctrl_prio_enc.sv | 20 ++
 rtl/int_ctrl.sv | 116 +++++++++++
 tb/tb_int_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt/exception controller.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] DEF_HANDLER_BASE = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE   = 32'h0000_0010;
  localparam int          SRC_OVF          = 0;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set bit of vec wins.
module prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 valid
);

  localparam int IDX_W = $clog2(W);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception controller: sticky pending capture, mask/enable gating,
// priority select, req/ack handshake to the front-end and EPC save.
//
//   state   | meaning
//   IDLE    | no request outstanding, waiting for an eligible source
//   REQ     | int_req held with frozen cause/int_vec until int_ack
//   SERVICE | handler running, EPC valid, requests blocked until iret
module int_ctrl
  import int_pkg::*;
#(
  parameter int                NUM_SRC      = 4,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] HANDLER_BASE = ADDR_W'(DEF_HANDLER_BASE),
  parameter logic [ADDR_W-1:0] VEC_STRIDE   = ADDR_W'(DEF_VEC_STRIDE),
  localparam int               IDX_W        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interrupt_en,
  input  logic               over_flow,
  input  logic [NUM_SRC-2:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               int_ack,
  input  logic               iret,
  output logic               int_req,
  output logic [ADDR_W-1:0]  int_vec,
  output logic [IDX_W-1:0]   cause,
  output logic [ADDR_W-1:0]  epc_out,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam logic [NUM_SRC-1:0] OVF_BIT = NUM_SRC'(1) << SRC_OVF;

  state_t             state, state_next;
  logic [NUM_SRC-1:0] src, src_q, src_edge, clr, en_vec, elig;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               load_cause, take_ack;
  logic [ADDR_W-1:0]  vec_next;

  assign src      = {irq, over_flow};
  assign src_edge = src & ~src_q;
  // Overflow bypasses both the global enable and the mask.
  assign en_vec   = {{(NUM_SRC-1){interrupt_en}}, 1'b1};
  assign elig     = pending & mask & en_vec;
  assign clr      = take_ack ? (NUM_SRC'(1) << cause) : '0;
  assign vec_next = HANDLER_BASE + ADDR_W'(win_idx) * VEC_STRIDE;

  prio_enc #(.W(NUM_SRC)) u_prio (
    .vec   (elig),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cause = 1'b0;
    take_ack   = 1'b0;
    int_req    = 1'b0;
    in_service = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_next = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          state_next = SERVICE;
          take_ack   = 1'b1;
        end
      end
      SERVICE: begin
        in_service = 1'b1;
        if (iret) begin
          state_next = win_valid ? REQ : IDLE;
          load_cause = win_valid;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '1;
      cause   <= '0;
      int_vec <= HANDLER_BASE;
      epc_out <= '0;
    end else begin
      src_q   <= src;
      // A new edge on a bit being acknowledged keeps it pending.
      pending <= (pending & ~clr) | src_edge;
      if (mask_we) mask <= mask_wdata | OVF_BIT;
      if (load_cause) begin
        cause   <= win_idx;
        int_vec <= vec_next;
      end
      if (take_ack) epc_out <= pc_in;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (NUM_SRC=4, ADDR_W=32): vector table
// through a scoreboard queue, then hand-driven latency/handshake sequences.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst, interrupt_en, over_flow, mask_we, int_ack, iret;
  logic [2:0]  irq;
  logic [3:0]  mask_wdata;
  logic [31:0] pc_in;
  logic        int_req, in_service;
  logic [31:0] int_vec, epc_out;
  logic [1:0]  cause;
  logic [3:0]  pending, mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_ctrl #(
    .NUM_SRC      (4),
    .ADDR_W       (32),
    .HANDLER_BASE (32'h0000_0100),
    .VEC_STRIDE   (32'h10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .interrupt_en (interrupt_en),
    .over_flow    (over_flow),
    .irq          (irq),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .pc_in        (pc_in),
    .int_ack      (int_ack),
    .iret         (iret),
    .int_req      (int_req),
    .int_vec      (int_vec),
    .cause        (cause),
    .epc_out      (epc_out),
    .in_service   (in_service),
    .pending      (pending),
    .mask         (mask)
  );

  typedef struct packed {
    logic        rst, ien, ovf;
    logic [2:0]  irq;
    logic        mwe;
    logic [3:0]  mwd;
    logic [31:0] pc;
    logic        ack, iret;
    logic        req;
    logic [1:0]  cause;
    logic [31:0] vec;
    logic        srv;
    logic [31:0] epc;
    logic [3:0]  pend;
    logic [3:0]  msk;
  } row_t;

  row_t  rows[$];
  string names[$];
  row_t  sb[$];
  string sb_names[$];

  function automatic row_t mk(
    input logic r, input logic ien, input logic ovf, input logic [2:0] iq,
    input logic mwe, input logic [3:0] mwd, input logic [31:0] pc,
    input logic ack, input logic ir,
    input logic rq, input logic [1:0] cs, input logic [31:0] vc, input logic sv,
    input logic [31:0] ep, input logic [3:0] pd, input logic [3:0] mk_);
    row_t x;
    x.rst = r;  x.ien = ien; x.ovf = ovf; x.irq = iq; x.mwe = mwe; x.mwd = mwd;
    x.pc = pc;  x.ack = ack; x.iret = ir;
    x.req = rq; x.cause = cs; x.vec = vc; x.srv = sv; x.epc = ep; x.pend = pd; x.msk = mk_;
    return x;
  endfunction

  task automatic add(input string n, input row_t r);
    names.push_back(n);
    rows.push_back(r);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    rst = r.rst; interrupt_en = r.ien; over_flow = r.ovf; irq = r.irq;
    mask_we = r.mwe; mask_wdata = r.mwd; pc_in = r.pc; int_ack = r.ack; iret = r.iret;
  endtask

  task automatic compare(input string n, input row_t e);
    chk($sformatf("%s.int_req", n),    32'(int_req),    32'(e.req));
    chk($sformatf("%s.cause", n),      32'(cause),      32'(e.cause));
    chk($sformatf("%s.int_vec", n),    int_vec,         e.vec);
    chk($sformatf("%s.in_service", n), 32'(in_service), 32'(e.srv));
    chk($sformatf("%s.epc_out", n),    epc_out,         e.epc);
    chk($sformatf("%s.pending", n),    32'(pending),    32'(e.pend));
    chk($sformatf("%s.mask", n),       32'(mask),       32'(e.msk));
  endtask

  task automatic quiet();
    rst = 1'b0; interrupt_en = 1'b0; over_flow = 1'b0; irq = 3'b000;
    mask_we = 1'b0; mask_wdata = 4'h0; pc_in = 32'h0; int_ack = 1'b0; iret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_rand;
    int          lat;
    bit          got;
    row_t        e;
    string       en;

    //   name             rst   ien   ovf   irq     mwe   mwd    pc            ack   iret  | req  cause  vec           srv   epc           pend   mask
    add("reset",       mk(1'b1,1'b0,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h0,4'hF));
    add("mask0",       mk(1'b0,1'b0,1'b0,3'b000,1'b1,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h0,4'h1));
    add("ovf_pulse",   mk(1'b0,1'b0,1'b1,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h1,4'h1));
    add("ovf_req",     mk(1'b0,1'b0,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd0,32'h100,1'b0,32'h000,4'h1,4'h1));
    add("ovf_ack",     mk(1'b0,1'b0,1'b0,3'b000,1'b0,4'h0,32'h040,1'b1,1'b0, 1'b0,2'd0,32'h100,1'b1,32'h040,4'h0,4'h1));
    add("ovf_srv",     mk(1'b0,1'b0,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b1,32'h040,4'h0,4'h1));
    add("ovf_iret",    mk(1'b0,1'b0,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b0,2'd0,32'h100,1'b0,32'h040,4'h0,4'h1));
    add("ack_in_idle", mk(1'b0,1'b0,1'b0,3'b000,1'b0,4'h0,32'h099,1'b1,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h040,4'h0,4'h1));
    add("mask_all",    mk(1'b0,1'b1,1'b0,3'b000,1'b1,4'hF,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h040,4'h0,4'hF));
    add("prio_edge",   mk(1'b0,1'b1,1'b0,3'b101,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h040,4'hA,4'hF));
    add("prio_req",    mk(1'b0,1'b1,1'b0,3'b101,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd1,32'h110,1'b0,32'h040,4'hA,4'hF));
    add("prio_ack",    mk(1'b0,1'b1,1'b0,3'b101,1'b0,4'h0,32'h200,1'b1,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h200,4'h8,4'hF));
    add("prio_srv",    mk(1'b0,1'b1,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h200,4'h8,4'hF));
    add("b2b_req",     mk(1'b0,1'b1,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b1,2'd3,32'h130,1'b0,32'h200,4'h8,4'hF));
    add("b2b_ack",     mk(1'b0,1'b1,1'b0,3'b000,1'b0,4'h0,32'h300,1'b1,1'b0, 1'b0,2'd3,32'h130,1'b1,32'h300,4'h0,4'hF));
    add("b2b_iret",    mk(1'b0,1'b1,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b0,2'd3,32'h130,1'b0,32'h300,4'h0,4'hF));
    add("gate_edge",   mk(1'b0,1'b0,1'b0,3'b010,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd3,32'h130,1'b0,32'h300,4'h4,4'hF));
    add("gate_hold",   mk(1'b0,1'b0,1'b0,3'b010,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd3,32'h130,1'b0,32'h300,4'h4,4'hF));
    add("gate_open",   mk(1'b0,1'b1,1'b0,3'b010,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd2,32'h120,1'b0,32'h300,4'h4,4'hF));
    add("hold_mask",   mk(1'b0,1'b1,1'b0,3'b011,1'b1,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd2,32'h120,1'b0,32'h300,4'h6,4'h1));
    add("hold_req",    mk(1'b0,1'b1,1'b0,3'b011,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd2,32'h120,1'b0,32'h300,4'h6,4'h1));
    add("hold_ack",    mk(1'b0,1'b1,1'b0,3'b011,1'b0,4'h0,32'h444,1'b1,1'b0, 1'b0,2'd2,32'h120,1'b1,32'h444,4'h2,4'h1));
    add("masked_iret", mk(1'b0,1'b1,1'b0,3'b011,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b0,2'd2,32'h120,1'b0,32'h444,4'h2,4'h1));
    add("mask_restore",mk(1'b0,1'b1,1'b0,3'b000,1'b1,4'hF,32'h000,1'b0,1'b0, 1'b0,2'd2,32'h120,1'b0,32'h444,4'h2,4'hF));
    add("unmask_req",  mk(1'b0,1'b1,1'b0,3'b000,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd1,32'h110,1'b0,32'h444,4'h2,4'hF));
    add("setclr_ack",  mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h555,1'b1,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h555,4'h2,4'hF));
    add("setclr_iret", mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b1,2'd1,32'h110,1'b0,32'h555,4'h2,4'hF));
    add("iret_in_req", mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b1, 1'b1,2'd1,32'h110,1'b0,32'h555,4'h2,4'hF));
    add("level_ack",   mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h666,1'b1,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h666,4'h0,4'hF));
    add("level_hold",  mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h666,4'h0,4'hF));
    add("srv_mask",    mk(1'b0,1'b1,1'b0,3'b001,1'b1,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd1,32'h110,1'b1,32'h666,4'h0,4'h1));
    add("rst_in_srv",  mk(1'b1,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h0,4'hF));
    add("rst_reedge",  mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h2,4'hF));
    add("reedge_req",  mk(1'b0,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b1,2'd1,32'h110,1'b0,32'h000,4'h2,4'hF));
    add("rst_in_req",  mk(1'b1,1'b1,1'b0,3'b001,1'b0,4'h0,32'h000,1'b0,1'b0, 1'b0,2'd0,32'h100,1'b0,32'h000,4'h0,4'hF));

    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      sb.push_back(rows[i]);
      sb_names.push_back(names[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e  = sb.pop_front();
        en = sb_names.pop_front();
        compare(en, e);
      end
    end

    // Overflow pulse: request latency measured with a bounded wait.
    quiet();
    @(posedge clk); #1;
    over_flow = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk); #1;
      over_flow = 1'b0;
      if (int_req) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk("ovf_latency", 32'(lat), 32'd2);
    chk("ovf_seq_cause", 32'(cause), 32'd0);
    chk("ovf_seq_vec", int_vec, 32'h100);

    // Hold the request a few cycles before acknowledging.
    repeat ($urandom_range(1, 4)) begin
      @(posedge clk); #1;
      chk("ovf_seq_req_held", 32'(int_req), 32'd1);
    end
    pc_rand = $urandom;
    pc_in   = pc_rand;
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    pc_in   = 32'h0;
    chk("ovf_seq_epc", epc_out, pc_rand);
    chk("ovf_seq_in_service", 32'(in_service), 32'd1);
    chk("ovf_seq_req_dropped", 32'(int_req), 32'd0);

    repeat ($urandom_range(1, 5)) begin
      @(posedge clk); #1;
      chk("ovf_seq_srv_held", 32'(in_service), 32'd1);
    end
    iret = 1'b1;
    @(posedge clk); #1;
    iret = 1'b0;
    chk("ovf_seq_iret_srv", 32'(in_service), 32'd0);
    chk("ovf_seq_iret_req", 32'(int_req), 32'd0);
    chk("ovf_seq_epc_kept", epc_out, pc_rand);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
